// File: rtl/crc16_pkg.sv
// CRC-16 frame sequencer shared types and constants.
// Used by crc16_frame_sequencer and crc16_lfsr_step.
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY_CCITT = 16'h1021;
   localparam logic [15:0] CRC16_INIT_FFFF  = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FETCH,
      S_SHIFT,
      S_APPEND,
      S_DONE
   } state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// One bit step of a CRC-16 LFSR.
// The x^16 term is implicit in the polynomial.
module crc16_lfsr_step #(
   parameter logic [15:0] POLY = 16'h1021
) (
   input  logic [15:0] crc_in,
   input  logic        bit_in,
   output logic [15:0] crc_next
);

   logic fb;

   // shift left, fold in polynomial when feedback is set
   always_comb begin
      fb       = crc_in[15] ^ bit_in;
      crc_next = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
   end

endmodule

// File: rtl/crc16_frame_sequencer.sv
// Byte-in, bit-serial-out framer appending a CRC-16 to each frame.
// Optional macro CRC16_ABORT_EN adds an abort input.
module crc16_frame_sequencer
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY  = CRC16_POLY_CCITT,
   parameter logic [15:0] INIT  = CRC16_INIT_FFFF,
   parameter int          LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
`ifdef CRC16_ABORT_EN
   input  logic             abort,
`endif
   output logic             byte_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [15:0]      crc_out,
   output logic             crc_done,
   output logic             busy,
   output logic             err_len
);

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_t           state, state_nxt;
   logic [15:0]      crc_reg;
   logic [15:0]      crc_nxt;
   logic [7:0]       shreg;
   logic [3:0]       bit_cnt;
   logic [LEN_W-1:0] byte_cnt;
   logic             last_bit;
   logic             last_byte;
   logic             abort_hit;

   assign last_bit  = (bit_cnt == 4'd7);
   assign last_byte = (byte_cnt == CNT_ONE);

`ifdef CRC16_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   crc16_lfsr_step #(
      .POLY (POLY)
   ) u_step (
      .crc_in   (crc_reg),
      .bit_in   (shreg[7]),
      .crc_next (crc_nxt)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next-state logic; abort overrides every other transition
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (start && (frame_len != '0)) state_nxt = S_LOAD;
         S_LOAD:
            state_nxt = S_FETCH;
         S_FETCH:
            if (byte_valid) state_nxt = S_SHIFT;
         S_SHIFT:
            if (last_bit) state_nxt = last_byte ? S_APPEND : S_FETCH;
         S_APPEND:
            if (bit_cnt == 4'd15) state_nxt = S_DONE;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_IDLE;
   end

   // datapath: crc register, shifter, counters, error pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc_reg  <= INIT;
         crc_out  <= 16'h0000;
         shreg    <= 8'h00;
         bit_cnt  <= 4'd0;
         byte_cnt <= '0;
         err_len  <= 1'b0;
      end else begin
         err_len <= 1'b0;
         if (abort_hit) begin
            err_len <= 1'b1;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start && (frame_len != '0)) byte_cnt <= frame_len;
                  if (start && (frame_len == '0)) err_len  <= 1'b1;
               end
               S_LOAD:
                  crc_reg <= INIT;
               S_FETCH:
                  if (byte_valid) begin
                     shreg   <= byte_data;
                     bit_cnt <= 4'd0;
                  end
               S_SHIFT: begin
                  crc_reg <= crc_nxt;
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (last_bit) begin
                     bit_cnt  <= 4'd0;
                     byte_cnt <= byte_cnt - CNT_ONE;
                     if (last_byte) crc_out <= crc_nxt;
                  end
               end
               S_APPEND:
                  bit_cnt <= bit_cnt + 4'd1;
               default: ;
            endcase
         end
      end
   end

   // Moore outputs decoded from state
   always_comb begin
      byte_ready = 1'b0;
      ser_out    = 1'b0;
      ser_valid  = 1'b0;
      crc_done   = 1'b0;
      busy       = (state != S_IDLE);
      unique case (state)
         S_FETCH:  byte_ready = 1'b1;
         S_SHIFT: begin
            ser_out   = shreg[7];
            ser_valid = 1'b1;
         end
         S_APPEND: begin
            ser_out   = crc_out[~bit_cnt];
            ser_valid = 1'b1;
         end
         S_DONE:   crc_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_crc16_frame_sequencer.sv
// Scoreboard bench for crc16_frame_sequencer.
// Define CRC16_ABORT_EN to also exercise abort.
module tb_crc16_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  frame_len;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        ser_out;
   logic        ser_valid;
   logic [15:0] crc_out;
   logic        crc_done;
   logic        busy;
   logic        err_len;
`ifdef CRC16_ABORT_EN
   logic        abort;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int ser_count;

   logic [7:0] fbytes[$];
   logic       exp_q[$];

   crc16_frame_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .frame_len  (frame_len),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
`ifdef CRC16_ABORT_EN
      .abort      (abort),
`endif
      .byte_ready (byte_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .crc_out    (crc_out),
      .crc_done   (crc_done),
      .busy       (busy),
      .err_len    (err_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_model();
      logic [15:0] c = 16'hFFFF;
      foreach (fbytes[i])
         for (int b = 7; b >= 0; b--)
            c = (c[15] ^ fbytes[i][b]) ?
                ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      return c;
   endfunction

   // serial monitor pops the scoreboard on every valid bit
   always @(negedge clk) begin
      if (ser_valid) begin
         ser_count++;
         if (exp_q.size() == 0) begin
            check("ser_extra", 32'(ser_out), 32'hx);
         end else begin
            logic e;
            e = exp_q.pop_front();
            check("ser_bit", 32'(ser_out), 32'(e));
         end
      end
   end

   // push frame bits plus model CRC, then drive the frame
   task automatic run_frame(input string tag,
                            input int stall_at,
                            input int stall_len,
                            input bit pulse,
                            input int rst_at,
                            input int abort_at,
                            input int exp_lat,
                            input logic [15:0] exp_crc);
      logic [15:0] m;
      int n, idx, edges, lat, stall_left;
      bit acc, done;
      logic [15:0] saved;
      n = fbytes.size();
      m = crc_model();
      foreach (fbytes[i])
         for (int b = 7; b >= 0; b--) exp_q.push_back(fbytes[i][b]);
      for (int b = 15; b >= 0; b--) exp_q.push_back(m[b]);
      ser_count  = 0;
      stall_left = stall_len;
      @(negedge clk);
      start     = 1'b1;
      frame_len = 8'(n);
      @(posedge clk);
      #1 start = 1'b0;
      idx = 0; edges = 0; done = 0; lat = 0;
      while (!done && edges < 2000) begin
         @(negedge clk);
         if (crc_done) begin
            done = 1;
            lat  = edges + 1;
            break;
         end
         if (rst_at != 0 && edges == rst_at) begin
            check({tag, "_pre_sv"}, 32'(ser_valid), 32'd1);
            #2 rst = 1'b0;
            #1 check({tag, "_outs"},
                     {ser_out, ser_valid, byte_ready, crc_done,
                      busy, err_len, crc_out}, 32'd0);
            exp_q.delete();
            byte_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
         end
`ifdef CRC16_ABORT_EN
         if (abort_at != 0 && edges == abort_at) begin
            check({tag, "_pre_sv"}, 32'(ser_valid), 32'd1);
            saved = crc_out;
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_err"}, 32'(err_len), 32'd1);
            check({tag, "_done"}, 32'(crc_done), 32'd0);
            check({tag, "_crc"}, 32'(crc_out), 32'(saved));
            exp_q.delete();
            byte_valid = 1'b0;
            @(negedge clk);
            check({tag, "_err_1shot"}, 32'(err_len), 32'd0);
            return;
         end
`else
         saved = 16'(abort_at);
`endif
         start     = pulse && (edges == 20);
         frame_len = pulse ? 8'd3 : 8'(n);
         if (idx < n && !(idx == stall_at && byte_ready && stall_left > 0)) begin
            byte_valid = 1'b1;
            byte_data  = fbytes[idx];
         end else begin
            if (idx == stall_at && byte_ready && stall_left > 0) stall_left--;
            byte_valid = 1'b0;
            byte_data  = 8'h00;
         end
         acc = byte_valid && byte_ready;
         @(posedge clk);
         edges++;
         if (acc) idx++;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      if (!done) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_crc"}, 32'(crc_out), 32'(exp_crc));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      check({tag, "_nbits"}, 32'(ser_count), 32'(8 * n + 16));
      check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      if (pulse)
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check({tag, "_noqueue"}, 32'(busy), 32'd0);
         end
   endtask

   task automatic load_123456789();
      fbytes.delete();
      for (int i = 0; i < 9; i++) fbytes.push_back(8'h31 + 8'(i));
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      frame_len  = 8'd0;
      byte_data  = 8'h00;
      byte_valid = 1'b0;
`ifdef CRC16_ABORT_EN
      abort      = 1'b0;
`endif
      #3;
      check("reset_outs",
            {ser_out, ser_valid, byte_ready, crc_done,
             busy, err_len, crc_out}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      load_123456789();
      run_frame("check_str", -1, 0, 0, 0, 0, 99, 16'h29B1);

      fbytes.delete();
      fbytes.push_back(8'h00);
      run_frame("one_zero", -1, 0, 0, 0, 0, 27, 16'hE1F0);

      @(negedge clk);
      start     = 1'b1;
      frame_len = 8'd0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("len0_err", 32'(err_len), 32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("len0_err_1shot", 32'(err_len), 32'd0);
      check("len0_busy2", 32'(busy), 32'd0);
      check("len0_crc", 32'(crc_out), 32'hE1F0);

      load_123456789();
      run_frame("stall", 3, 5, 0, 0, 0, 104, 16'h29B1);

      load_123456789();
      run_frame("rst_mid", -1, 0, 0, 14, 0, 0, 16'h0000);
      repeat (2) @(negedge clk);
      fbytes.delete();
      fbytes.push_back(8'hA5);
      fbytes.push_back(8'h3C);
      run_frame("after_rst", -1, 0, 0, 0, 0, 36, crc_model());

      load_123456789();
      run_frame("busy_start", -1, 0, 1, 0, 0, 99, 16'h29B1);

`ifdef CRC16_ABORT_EN
      fbytes.delete();
      fbytes.push_back(8'h00);
      run_frame("abort", -1, 0, 0, 0, 15, 0, 16'h0000);
      fbytes.delete();
      fbytes.push_back(8'h00);
      run_frame("post_abort", -1, 0, 0, 0, 0, 27, 16'hE1F0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
